// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared constants and types for the frame-interval timer.
package timer_pkg;

   localparam int DIV_60HZ_50MHZ = 833334;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } timer_state_t;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - DIV-cycle prescaler; wraps to 0 after DIV-1 and pulses tick.
module frame_tick_gen
   import timer_pkg::*;
#(
   parameter int DIV   = DIV_60HZ_50MHZ,
   parameter int DIV_W = 20
) (
   input  logic clk,
   input  logic resetn,
   input  logic run,
   input  logic clear,
   input  logic hold,
   output logic tick,
   output logic wrap
);

   localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;

   // wrap is the same-edge strobe the frame counter needs; tick is its registered copy
   assign wrap = run && !hold && !clear && (cnt_q == LAST);
   assign tick = tick_q;

   always_comb begin
      cnt_d  = cnt_q;
      tick_d = wrap;
      if (clear) begin
         cnt_d = '0;
      end else if (run && !hold) begin
         cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

endmodule

// File: rtl/interval_timer.sv
// rtl/interval_timer.sv - frame-interval timer with one-shot/periodic done pulses.
// Optional INTERVAL_TIMER_PAUSE_EN adds a pause input that freezes counting in RUN.
module interval_timer
   import timer_pkg::*;
#(
   parameter int DIV   = DIV_60HZ_50MHZ,
   parameter int DIV_W = 20,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             stop,
`ifdef INTERVAL_TIMER_PAUSE_EN
   input  logic             pause,
`endif
   input  logic             periodic,
   input  logic [CNT_W-1:0] frames,
   output logic             busy,
   output logic             done,
   output logic             frame_tick,
   output logic [CNT_W-1:0] frames_left
);

   timer_state_t     state_q, state_d;
   logic [CNT_W-1:0] frames_left_q, frames_left_d;
   logic [CNT_W-1:0] reload_q, reload_d;
   logic             mode_q, mode_d;
   logic             done_q, done_d;
   logic             hold;
   logic             wrap;

`ifdef INTERVAL_TIMER_PAUSE_EN
   assign hold = pause && (state_q == RUN);
`else
   assign hold = 1'b0;
`endif

   frame_tick_gen #(
      .DIV   (DIV),
      .DIV_W (DIV_W)
   ) u_tick_gen (
      .clk    (clk),
      .resetn (resetn),
      .run    (state_q == RUN),
      .clear  (start || stop),
      .hold   (hold),
      .tick   (frame_tick),
      .wrap   (wrap)
   );

   always_comb begin
      state_d       = state_q;
      frames_left_d = frames_left_q;
      reload_d      = reload_q;
      mode_d        = mode_q;
      done_d        = 1'b0;
      if (stop) begin
         state_d       = IDLE;
         frames_left_d = '0;
      end else if (start) begin
         if (frames == '0) begin
            // zero-length interval completes immediately
            done_d        = 1'b1;
            state_d       = IDLE;
            frames_left_d = '0;
         end else begin
            reload_d      = frames;
            frames_left_d = frames;
            mode_d        = periodic;
            state_d       = RUN;
         end
      end else if (state_q == RUN && wrap && frames_left_q != '0) begin
         if (frames_left_q == CNT_W'(1)) begin
            done_d = 1'b1;
            if (mode_q == MODE_PERIODIC) begin
               frames_left_d = reload_q;
            end else begin
               frames_left_d = '0;
               state_d       = IDLE;
            end
         end else begin
            frames_left_d = frames_left_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= IDLE;
         frames_left_q <= '0;
         reload_q      <= '0;
         mode_q        <= MODE_ONESHOT;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         frames_left_q <= frames_left_d;
         reload_q      <= reload_d;
         mode_q        <= mode_d;
         done_q        <= done_d;
      end
   end

   assign busy        = (state_q == RUN);
   assign done        = done_q;
   assign frames_left = frames_left_q;

endmodule

// File: tb/tb_interval_timer.sv
// tb/tb_interval_timer.sv - self-checking bench for interval_timer (DIV=4, CNT_W=8).
module tb_interval_timer;

   localparam int DIV   = 4;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             resetn = 1'b0;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic             pause = 1'b0;
   logic             periodic = 1'b0;
   logic [CNT_W-1:0] frames = '0;
   logic             busy, done, frame_tick;
   logic [CNT_W-1:0] frames_left;

   int checks = 0;
   int errors = 0;

   // reference model: elapsed running cycles since the last accepted start
   bit m_run, m_per, m_done, m_tick;
   int m_e, m_n, m_left;

   always #5 clk = ~clk;

   interval_timer #(
      .DIV   (DIV),
      .DIV_W (3),
      .CNT_W (CNT_W)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .start       (start),
      .stop        (stop),
`ifdef INTERVAL_TIMER_PAUSE_EN
      .pause       (pause),
`endif
      .periodic    (periodic),
      .frames      (frames),
      .busy        (busy),
      .done        (done),
      .frame_tick  (frame_tick),
      .frames_left (frames_left)
   );

   task automatic model_reset();
      m_run = 0; m_per = 0; m_done = 0; m_tick = 0; m_e = 0; m_n = 0; m_left = 0;
   endtask

   task automatic model_edge();
      bit p;
      int k;
`ifdef INTERVAL_TIMER_PAUSE_EN
      p = pause;
`else
      p = 0;
`endif
      m_done = 0;
      m_tick = 0;
      if (!resetn) begin
         model_reset();
      end else if (stop) begin
         m_run = 0; m_left = 0;
      end else if (start) begin
         if (frames == 0) begin
            m_done = 1; m_run = 0; m_left = 0;
         end else begin
            m_run = 1; m_e = 0; m_n = int'(frames); m_per = periodic; m_left = m_n;
         end
      end else if (m_run && !p) begin
         m_e++;
         if (m_e % DIV == 0) begin
            m_tick = 1;
            k = m_e / DIV;
            if (m_per) begin
               m_left = m_n - (k % m_n);
               m_done = (k % m_n == 0);
            end else begin
               m_left = m_n - k;
               if (k == m_n) begin
                  m_done = 1; m_run = 0;
               end
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      model_reset();
      resetn = 1'b0;
      step();
      checks++;
      if ({busy, done, frame_tick, frames_left} !== 11'd0) begin
         errors++;
         $display("FAIL reset_state: busy=%0b done=%0b tick=%0b left=%0d, want all 0", busy, done, frame_tick, frames_left);
      end
      resetn = 1'b1;
      step();
      start = 1'b1; frames = 8'd3; periodic = 1'b0;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      checks++;
      if (frames_left !== 8'd2 || busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_pre: left=%0d busy=%0b, want 2 1", frames_left, busy);
      end
      #2 resetn = 1'b0;
      #1;
      checks++;
      if ({busy, done, frame_tick, frames_left} !== 11'd0) begin
         errors++;
         $display("FAIL reset_async: busy=%0b done=%0b tick=%0b left=%0d, want all 0", busy, done, frame_tick, frames_left);
      end
      for (int i = 0; i < 12; i++) begin
         step();
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: done=%0b busy=%0b, want 0 0", done, busy);
         end
      end
      resetn = 1'b1;
      step();
   endtask

   task automatic test_oneshot();
      start = 1'b1; frames = 8'd3; periodic = 1'b0;
      step();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || frames_left !== 8'd3 || done !== 1'b0) begin
         errors++;
         $display("FAIL oneshot_T: busy=%0b left=%0d done=%0b, want 1 3 0", busy, frames_left, done);
      end
      for (int i = 1; i <= 14; i++) begin
         step();
         checks++;
         if (frame_tick !== (i % 4 == 0 && i <= 12) || done !== (i == 12) || busy !== (i < 12)
             || frames_left !== 8'((i < 12) ? 3 - i / 4 : 0)) begin
            errors++;
            $display("FAIL oneshot_T+%0d: tick=%0b done=%0b busy=%0b left=%0d", i, frame_tick, done, busy, frames_left);
         end
      end
   endtask

   task automatic test_periodic();
      start = 1'b1; frames = 8'd2; periodic = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i <= 25; i++) begin
         step();
         checks++;
         if (done !== (i % 8 == 0) || busy !== 1'b1 || frames_left !== 8'(2 - (i / 4) % 2)) begin
            errors++;
            $display("FAIL periodic_T+%0d: done=%0b busy=%0b left=%0d", i, done, busy, frames_left);
         end
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      checks++;
      if (busy !== 1'b0 || frames_left !== 8'd0 || done !== 1'b0 || frame_tick !== 1'b0) begin
         errors++;
         $display("FAIL periodic_stop: busy=%0b left=%0d done=%0b tick=%0b, want 0", busy, frames_left, done, frame_tick);
      end
   endtask

   task automatic test_zero_and_priority();
      start = 1'b1; frames = 8'd0;
      step();
      start = 1'b0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_len: done=%0b busy=%0b, want 1 0", done, busy);
      end
      step();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL zero_len_pulse: done=%0b, want 0", done);
      end
      start = 1'b1; frames = 8'd1; periodic = 1'b0;
      step();
      start = 1'b0;
      step(); step();
      start = 1'b1; stop = 1'b1;
      step();
      start = 1'b0; stop = 1'b0;
      checks++;
      if (busy !== 1'b0 || frames_left !== 8'd0) begin
         errors++;
         $display("FAIL start_stop: busy=%0b left=%0d, want 0 0", busy, frames_left);
      end
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (done !== 1'b0) begin
            errors++;
            $display("FAIL start_stop_nodone: done=%0b at +%0d", done, i);
         end
      end
   endtask

   task automatic test_restart();
      start = 1'b1; frames = 8'd3; periodic = 1'b0;
      step();
      for (int i = 1; i <= 30; i++) begin
         start = (i == 6);
         frames = 8'd5;
         step();
         checks++;
         if (done !== (i == 26)) begin
            errors++;
            $display("FAIL restart_T+%0d: done=%0b want %0b", i, done, i == 26);
         end
      end
      start = 1'b0;
   endtask

`ifdef INTERVAL_TIMER_PAUSE_EN
   task automatic test_pause();
      start = 1'b1; frames = 8'd1; periodic = 1'b0;
      step();
      start = 1'b0;
      for (int i = 1; i <= 18; i++) begin
         pause = (i >= 2 && i <= 11);
         step();
         checks++;
         if (done !== (i == 14) || busy !== (i < 14)) begin
            errors++;
            $display("FAIL pause_T+%0d: done=%0b busy=%0b", i, done, busy);
         end
      end
      pause = 1'b0;
   endtask
`endif

   task automatic test_random();
      int bad = 0;
      stop = 1'b1;
      step();
      stop = 1'b0;
      for (int i = 0; i < 600; i++) begin
         start    = ($urandom_range(0, 13) == 0);
         stop     = ($urandom_range(0, 39) == 0);
         periodic = $urandom_range(0, 1);
         frames   = 8'($urandom_range(0, 4));
`ifdef INTERVAL_TIMER_PAUSE_EN
         pause    = ($urandom_range(0, 5) == 0);
`endif
         step();
         checks++;
         if (busy !== m_run || done !== m_done || frame_tick !== m_tick || frames_left !== 8'(m_left)) begin
            errors++;
            if (bad < 10)
               $display("FAIL random_%0d: busy=%0b/%0b done=%0b/%0b tick=%0b/%0b left=%0d/%0d (got/want)",
                        i, busy, m_run, done, m_done, frame_tick, m_tick, frames_left, m_left);
            bad++;
         end
      end
      start = 1'b0; stop = 1'b0; pause = 1'b0;
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_periodic();
      test_zero_and_priority();
      test_restart();
`ifdef INTERVAL_TIMER_PAUSE_EN
      test_pause();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
